// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Brief    : Multi-cycle sequencer for the shared 74181-style ALU. Takes a
//             3-bit encoded op, gates the operand onto the ALU bus, drives the
//             one-hot op lines through the settle window, then strobes the
//             accumulator load and pulses DONE.
//  Options  : define ALU_SEQ_FLAGS_EN to add ALU_F/ALU_CN4 inputs and
//             registered ZF/CF flag outputs captured on the write-back edge.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int EXEC_CYCLES = 1
`ifdef ALU_SEQ_FLAGS_EN
   ,parameter int DW          = 8
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic          abort,
    output logic          ready,
    output logic          open,
    output logic [7:0]    opsel,
    output logic          acld,
    output logic          done
`ifdef ALU_SEQ_FLAGS_EN
   ,input  logic [DW-1:0] alu_f,
    input  logic          alu_cn4,
    output logic          zf,
    output logic          cf
`endif
);

    // Settle window clamped into the 4-bit counter range; 0 behaves as 1.
    localparam int         C_EXEC_EFF = (EXEC_CYCLES < 1)  ? 1  :
                                        (EXEC_CYCLES > 15) ? 15 : EXEC_CYCLES;
    localparam logic [3:0] C_CNT_INIT = 4'(C_EXEC_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPND = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q,    op_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       ready_q, ready_d;
    logic       open_q,  open_d;
    logic [7:0] opsel_q, opsel_d;
    logic       acld_q,  acld_d;
    logic       done_q,  done_d;
`ifdef ALU_SEQ_FLAGS_EN
    logic       zf_q,    zf_d;
    logic       cf_q,    cf_d;
    logic       w_arith;
`endif

    // Next-state logic plus output decode of the next state, so the registered
    // outputs always reflect the state register with no input-to-output path.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    state_d = S_OPND;
                end
            end
            S_OPND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = C_CNT_INIT;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // Write-back is already committed here, so abort is ignored.
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        open_d  = (state_d == S_OPND) || (state_d == S_EXEC) || (state_d == S_WB);
        opsel_d = ((state_d == S_EXEC) || (state_d == S_WB)) ? (8'h80 >> op_d) : 8'h00;
        acld_d  = (state_d == S_WB);
        done_d  = (state_d == S_DONE);

`ifdef ALU_SEQ_FLAGS_EN
        // Logic ops never produce a carry; arithmetic ops take the inverted CN4.
        w_arith = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd6) || (op_q == 3'd7);
        zf_d    = zf_q;
        cf_d    = cf_q;
        if (state_q == S_WB) begin
            zf_d = (alu_f == '0);
            cf_d = w_arith ? ~alu_cn4 : 1'b0;
        end
`endif
    end

    // State, operand latch, settle counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            open_q  <= 1'b0;
            opsel_q <= 8'h00;
            acld_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            open_q  <= open_d;
            opsel_q <= opsel_d;
            acld_q  <= acld_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_FLAGS_EN
            zf_q    <= zf_d;
            cf_q    <= cf_d;
`endif
        end
    end

    assign ready = ready_q;
    assign open  = open_q;
    assign opsel = opsel_q;
    assign acld  = acld_q;
    assign done  = done_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign zf    = zf_q;
    assign cf    = cf_q;
`endif

endmodule
`default_nettype wire
